// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: bundles the instruction handshake and the datapath control/status
// signals of the ALU sequencer.
//   instr_valid/instr_ready/instr : instruction handshake from the host side
//   func/crIn/leftAddr/rightAddr/destAddr/writeEn/selInput : datapath control
//   crOut : carry returned by the datapath
//   busy/carry_flag/op_done : sequencer status
// Modport slave is the sequencer; master is the host/datapath side.
interface alu_sequencer_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned FUNC_W = 3,
  parameter int unsigned CNT_W  = 4
);
  localparam int unsigned INSTR_W = FUNC_W + 3 * ADDR_W + 3 + CNT_W;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [FUNC_W-1:0]  func;
  logic               crIn;
  logic [ADDR_W-1:0]  leftAddr;
  logic [ADDR_W-1:0]  rightAddr;
  logic [ADDR_W-1:0]  destAddr;
  logic               writeEn;
  logic               selInput;
  logic               crOut;
  logic               busy;
  logic               carry_flag;
  logic               op_done;

  modport slave (
    input  instr_valid, instr, crOut,
    output instr_ready, func, crIn, leftAddr, rightAddr, destAddr,
           writeEn, selInput, busy, carry_flag, op_done
  );

  modport master (
    output instr_valid, instr, crOut,
    input  instr_ready, func, crIn, leftAddr, rightAddr, destAddr,
           writeEn, selInput, busy, carry_flag, op_done
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one instruction per valid/ready handshake and expands it into
// count+1 single-cycle micro-ops for the register-file/ALU datapath. Register addresses
// auto-increment (mod 2^ADDR_W) and the carry chains crOut -> crIn between micro-ops.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : alu_sequencer_if.slave (handshake, datapath control, status)
// Instruction layout (LSB first): func, dest, left, right, selInput, carry seed,
// noWrite, count.
module alu_sequencer #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned FUNC_W = 3,
  parameter int unsigned CNT_W  = 4
) (
  input  logic           clock,
  input  logic           reset,
  alu_sequencer_if.slave bus
);
  localparam int unsigned DEST_LO  = FUNC_W;
  localparam int unsigned LEFT_LO  = DEST_LO + ADDR_W;
  localparam int unsigned RIGHT_LO = LEFT_LO + ADDR_W;
  localparam int unsigned SEL_BIT  = RIGHT_LO + ADDR_W;
  localparam int unsigned SEED_BIT = SEL_BIT + 1;
  localparam int unsigned NOWR_BIT = SEED_BIT + 1;
  localparam int unsigned CNT_LO   = NOWR_BIT + 1;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [FUNC_W-1:0]  func_q, func_d;
  logic [ADDR_W-1:0]  dest_q, dest_d;
  logic [ADDR_W-1:0]  left_q, left_d;
  logic [ADDR_W-1:0]  right_q, right_d;
  logic               cr_in_q, cr_in_d;
  logic               write_en_q, write_en_d;
  logic               sel_input_q, sel_input_d;
  logic               busy_q, busy_d;
  logic               carry_flag_q, carry_flag_d;
  logic               op_done_q, op_done_d;

  logic instr_ready;
  logic accept;
  logic last_op;

  assign last_op     = (state_q == EXEC) && (remaining_q == '0);
  // Ready is gated by reset so nothing can be accepted while reset is held.
  assign instr_ready = !reset && ((state_q == IDLE) || last_op);
  assign accept      = bus.instr_valid && instr_ready;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      func_q       <= '0;
      dest_q       <= '0;
      left_q       <= '0;
      right_q      <= '0;
      cr_in_q      <= 1'b0;
      write_en_q   <= 1'b0;
      sel_input_q  <= 1'b0;
      busy_q       <= 1'b0;
      carry_flag_q <= 1'b0;
      op_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      func_q       <= func_d;
      dest_q       <= dest_d;
      left_q       <= left_d;
      right_q      <= right_d;
      cr_in_q      <= cr_in_d;
      write_en_q   <= write_en_d;
      sel_input_q  <= sel_input_d;
      busy_q       <= busy_d;
      carry_flag_q <= carry_flag_d;
      op_done_q    <= op_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: if (remaining_q == '0 && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered output logic. instr is only sampled on accept, so an undriven
  // instr while instr_valid is low never reaches a flop.
  always_comb begin
    remaining_d  = remaining_q;
    func_d       = func_q;
    dest_d       = dest_q;
    left_d       = left_q;
    right_d      = right_q;
    cr_in_d      = cr_in_q;
    write_en_d   = write_en_q;
    sel_input_d  = sel_input_q;
    carry_flag_d = carry_flag_q;
    op_done_d    = last_op;
    busy_d       = (state_d == EXEC);

    if (state_q == EXEC) carry_flag_d = bus.crOut;

    if (accept) begin
      func_d      = bus.instr[FUNC_W-1:0];
      dest_d      = bus.instr[DEST_LO +: ADDR_W];
      left_d      = bus.instr[LEFT_LO +: ADDR_W];
      right_d     = bus.instr[RIGHT_LO +: ADDR_W];
      sel_input_d = bus.instr[SEL_BIT];
      cr_in_d     = bus.instr[SEED_BIT];
      write_en_d  = !bus.instr[NOWR_BIT];
      remaining_d = bus.instr[CNT_LO +: CNT_W];
    end else if (state_q == EXEC) begin
      if (remaining_q != '0) begin
        remaining_d = remaining_q - 1'b1;
        dest_d      = dest_q + 1'b1;
        left_d      = left_q + 1'b1;
        right_d     = right_q + 1'b1;
        cr_in_d     = bus.crOut;
      end else begin
        write_en_d  = 1'b0;
      end
    end
  end

  assign bus.instr_ready = instr_ready;
  assign bus.func        = func_q;
  assign bus.crIn        = cr_in_q;
  assign bus.leftAddr    = left_q;
  assign bus.rightAddr   = right_q;
  assign bus.destAddr    = dest_q;
  assign bus.writeEn     = write_en_q;
  assign bus.selInput    = sel_input_q;
  assign bus.busy        = busy_q;
  assign bus.carry_flag  = carry_flag_q;
  assign bus.op_done     = op_done_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed, table-driven bench for alu_sequencer plus hand-written
// sequences for back-to-back issue and reset in the middle of a chain.
module tb_alu_sequencer;
  logic clock;
  logic reset;

  alu_sequencer_if #(.ADDR_W(4), .FUNC_W(3), .CNT_W(4)) bus ();

  alu_sequencer #(.ADDR_W(4), .FUNC_W(3), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] func;
    logic [3:0] dest, left, right;
    logic       sel, seed, nw;
    logic [3:0] cnt;
    logic       crout;
    logic [3:0] e_dest, e_left, e_right;
    logic       e_we, e_cf;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [21:0] mk(input logic [2:0] f, input logic [3:0] d, input logic [3:0] l,
                                     input logic [3:0] r, input logic s, input logic sd,
                                     input logic nw, input logic [3:0] c);
    return {c, nw, sd, s, r, l, d, f};
  endfunction

  int done_cnt;

  initial begin
    //            func  dest   left   right  sel   seed  nw    cnt    cr    e_dest e_left e_right we   cf
    vecs[0] = '{3'd5, 4'd2,  4'd1,  4'd3,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd2,  4'd1,  4'd3,  1'b1, 1'b0};
    vecs[1] = '{3'd1, 4'd12, 4'd4,  4'd8,  1'b0, 1'b0, 1'b0, 4'd3,  1'b1, 4'd15, 4'd7,  4'd11, 1'b1, 1'b1};
    vecs[2] = '{3'd2, 4'd14, 4'd15, 4'd0,  1'b0, 1'b1, 1'b0, 4'd2,  1'b0, 4'd0,  4'd1,  4'd2,  1'b1, 1'b0};
    vecs[3] = '{3'd3, 4'd5,  4'd6,  4'd7,  1'b1, 1'b0, 1'b1, 4'd1,  1'b1, 4'd6,  4'd7,  4'd8,  1'b0, 1'b1};
    vecs[4] = '{3'd7, 4'd0,  4'd0,  4'd0,  1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 4'd15, 4'd15, 4'd15, 1'b1, 1'b0};

    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = 'x;
    bus.crOut = 1'b0;
    step();
    step();
    chk("rst_ready", 32'(bus.instr_ready), 0);
    chk("rst_we", 32'(bus.writeEn), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.op_done), 0);
    chk("rst_cf", 32'(bus.carry_flag), 0);
    chk("rst_crin", 32'(bus.crIn), 0);
    chk("rst_sel", 32'(bus.selInput), 0);
    chk("rst_func", 32'(bus.func), 0);
    chk("rst_addr", 32'({bus.destAddr, bus.leftAddr, bus.rightAddr}), 0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(bus.instr_ready), 1);

    // Table-driven single instructions
    foreach (vecs[k]) begin
      int n;
      n = int'(vecs[k].cnt);
      bus.crOut = vecs[k].crout;
      bus.instr = mk(vecs[k].func, vecs[k].dest, vecs[k].left, vecs[k].right,
                     vecs[k].sel, vecs[k].seed, vecs[k].nw, vecs[k].cnt);
      bus.instr_valid = 1'b1;
      chk("ready_idle", 32'(bus.instr_ready), 1);
      step();
      bus.instr_valid = 1'b0;
      bus.instr = 'x;
      for (int i = 0; i <= n; i++) begin
        chk("busy", 32'(bus.busy), 1);
        chk("we", 32'(bus.writeEn), 32'(vecs[k].e_we));
        chk("func", 32'(bus.func), 32'(vecs[k].func));
        chk("sel", 32'(bus.selInput), 32'(vecs[k].sel));
        chk("crin", 32'(bus.crIn), 32'(i == 0 ? vecs[k].seed : vecs[k].crout));
        chk("done_mid", 32'(bus.op_done), 0);
        if (i == 0)
          chk("first_addr", 32'({bus.destAddr, bus.leftAddr, bus.rightAddr}),
              32'({vecs[k].dest, vecs[k].left, vecs[k].right}));
        if (i == n)
          chk("last_addr", 32'({bus.destAddr, bus.leftAddr, bus.rightAddr}),
              32'({vecs[k].e_dest, vecs[k].e_left, vecs[k].e_right}));
        step();
      end
      chk("done_pulse", 32'(bus.op_done), 1);
      chk("busy_end", 32'(bus.busy), 0);
      chk("we_end", 32'(bus.writeEn), 0);
      chk("carry_flag", 32'(bus.carry_flag), 32'(vecs[k].e_cf));
      step();
      chk("done_clear", 32'(bus.op_done), 0);
    end

    // Wrap: intermediate micro-op of vector 2 style chain checked explicitly
    bus.crOut = 1'b0;
    bus.instr = mk(3'd2, 4'd14, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0, 4'd2);
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    step();
    chk("wrap_mid", 32'({bus.destAddr, bus.leftAddr, bus.rightAddr}), 32'({4'd15, 4'd0, 4'd1}));
    step();
    step();
    step();

    // Back-to-back: B presented early (ignored while not ready), accepted on A's last op
    done_cnt = 0;
    bus.crOut = 1'b0;
    bus.instr = mk(3'd4, 4'd3, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0, 4'd1);
    bus.instr_valid = 1'b1;
    step();                                   // A op0
    done_cnt += int'(bus.op_done);
    bus.instr = mk(3'd6, 4'd9, 4'd10, 4'd11, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("b2b_notready", 32'(bus.instr_ready), 0);
    chk("b2b_a0_dest", 32'(bus.destAddr), 3);
    step();                                   // A op1, B held
    done_cnt += int'(bus.op_done);
    chk("b2b_a1_dest", 32'(bus.destAddr), 4);
    chk("b2b_a1_func", 32'(bus.func), 4);
    chk("b2b_ready_last", 32'(bus.instr_ready), 1);
    step();                                   // B op0, no bubble
    done_cnt += int'(bus.op_done);
    bus.instr_valid = 1'b0;
    bus.instr = 'x;
    chk("b2b_busy", 32'(bus.busy), 1);
    chk("b2b_done_a", 32'(bus.op_done), 1);
    chk("b2b_b_dest", 32'(bus.destAddr), 9);
    chk("b2b_b_func", 32'(bus.func), 6);
    chk("b2b_b_we", 32'(bus.writeEn), 1);
    step();
    done_cnt += int'(bus.op_done);
    chk("b2b_idle", 32'(bus.busy), 0);
    step();
    done_cnt += int'(bus.op_done);
    chk("b2b_done_total", 32'(done_cnt), 2);

    // Reset in the 2nd micro-op of a count=5 chain
    bus.crOut = 1'b1;
    bus.instr = mk(3'd1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd5);
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    bus.instr = 'x;
    step();
    chk("rstmid_op1", 32'(bus.destAddr), 1);
    reset = 1'b1;
    #1;
    chk("rstmid_ready_in_rst", 32'(bus.instr_ready), 0);
    step();
    chk("rstmid_we", 32'(bus.writeEn), 0);
    chk("rstmid_busy", 32'(bus.busy), 0);
    chk("rstmid_done", 32'(bus.op_done), 0);
    reset = 1'b0;
    #1;
    chk("rstmid_ready", 32'(bus.instr_ready), 1);
    step();
    chk("rstmid_no_done", 32'(bus.op_done), 0);
    chk("rstmid_idle", 32'(bus.busy), 0);
    step();
    chk("rstmid_no_done2", 32'(bus.op_done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
